// File: rtl/fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and constants for the instruction-fetch front end
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int          FETCH_XLEN  = 32;
  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP         = 32'h0000_0013;
  // Bounds the number of stale responses still in flight after redirects
  localparam int          DISCARD_W   = 16;

  typedef struct packed {
    logic [31:0]           instr;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit_if : imem, redirect, decode and perf signals of the fetch unit
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pcplus4_d;
  logic            valid_d;
  logic            ready_d;
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_redirects;
  logic [31:0]     perf_stalls;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output instr_d, pc_d, pcplus4_d, valid_d,
    input  ready_d,
    output perf_fetched, perf_redirects, perf_stalls
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  instr_d, pc_d, pcplus4_d, valid_d,
    output ready_d,
    input  perf_fetched, perf_redirects, perf_stalls
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_fifo : synchronous first-word-fall-through queue with flush
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = fetch_entry_t,
  localparam int PW      = ptr_w(DEPTH)
) (
  input  wire logic    clk,
  input  wire logic    reset,
  input  wire logic    push,
  input  wire ENTRY_T  push_entry,
  input  wire logic    pop,
  input  wire logic    flush,
  output      ENTRY_T  head,
  output      logic    empty,
  output      logic [PW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  ENTRY_T        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push)
        wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop && !empty)
        rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_unit : decoupled instruction fetch with redirect and stale-drop logic
// Optional perf counters enabled by defining FETCH_PERF_EN.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input wire logic    clk,
  input wire logic    reset,
  fetch_unit_if.master bus
);

  localparam int              PW       = ptr_w(DEPTH);
  localparam logic [PW:0]     DEPTH_C  = (PW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_M  = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_AL = RESET_PC & ALIGN_M;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0]      pc_f_q, pc_f_d;
  logic [XLEN-1:0]      rsp_pc_q, rsp_pc_d;
  logic [PW-1:0]        outstanding_q, outstanding_d;
  logic [DISCARD_W-1:0] discard_q, discard_d;

  logic          issue;
  logic          accept;
  logic          valid;
  logic          pop;
  logic          empty;
  logic [PW-1:0] count;
  entry_t        head;
  entry_t        push_entry;

  // Credit covers queued plus live in-flight words, so a push always has room
  assign issue  = !reset && !bus.redirect &&
                  (({1'b0, count} + {1'b0, outstanding_q}) < DEPTH_C);
  assign accept = bus.imem_rvalid && (discard_q == '0) && !bus.redirect;
  assign valid  = !empty && !reset;
  assign pop    = valid && bus.ready_d && !bus.redirect;

  assign push_entry = '{instr: bus.imem_rdata, pc: rsp_pc_q};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect),
    .head       (head),
    .empty      (empty),
    .count      (count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_f_q;
  assign bus.valid_d   = valid;
  assign bus.instr_d   = empty ? NOP : head.instr;
  assign bus.pc_d      = head.pc;
  assign bus.pcplus4_d = head.pc + STEP;

  always_comb begin
    pc_f_d        = pc_f_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (bus.redirect) begin
      // Every live request becomes stale; a response arriving now is stale too
      pc_f_d        = bus.redirect_pc & ALIGN_M;
      rsp_pc_d      = bus.redirect_pc & ALIGN_M;
      outstanding_d = '0;
      discard_d     = discard_q + DISCARD_W'(outstanding_q)
                      - DISCARD_W'(bus.imem_rvalid);
    end else begin
      if (issue)
        pc_f_d = pc_f_q + STEP;
      if (accept)
        rsp_pc_d = rsp_pc_q + STEP;
      if (bus.imem_rvalid && discard_q != '0)
        discard_d = discard_q - DISCARD_W'(1);
      outstanding_d = outstanding_q + PW'(issue) - PW'(accept);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q        <= RESET_AL;
      rsp_pc_q      <= RESET_AL;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_f_q        <= pc_f_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q + {31'd0, pop};
    perf_redirects_d = perf_redirects_q + {31'd0, bus.redirect};
    perf_stalls_d    = perf_stalls_q + {31'd0, valid && !bus.ready_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
      perf_stalls_q    <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
      perf_stalls_q    <= perf_stalls_d;
    end
  end

  assign bus.perf_fetched   = perf_fetched_q;
  assign bus.perf_redirects = perf_redirects_q;
  assign bus.perf_stalls    = perf_stalls_q;
`else
  assign bus.perf_fetched   = '0;
  assign bus.perf_redirects = '0;
  assign bus.perf_stalls    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_unit : randomized scoreboard bench for fetch_unit
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due = 0;
  int          lat_lo = 1, lat_hi = 1;

  int n_xfer = 0, n_stall = 0, n_redir = 0;
  bit inc_x = 0, inc_s = 0, inc_r = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Instruction memory: in order, variable latency, never back-pressured
  always @(negedge clk) begin
    int due;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
      last_due = 0;
    end else if (bus.imem_req) begin
      check("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(bus.imem_addr);
      pend_due.push_back(due);
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
  end

  // Monitor: every decode transfer must match the head of the expected stream
  always @(negedge clk) begin
    logic [31:0] e;
    inc_x = 0; inc_s = 0; inc_r = 0;
    if (!reset) begin
      inc_r = bus.redirect;
      inc_s = bus.valid_d && !bus.ready_d;
      if (bus.valid_d && bus.ready_d && !bus.redirect) begin
        inc_x = 1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL xfer_unexpected: got pc %h, expected no transfer", bus.pc_d);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc",    bus.pc_d,      e);
          check("xfer_instr", bus.instr_d,   mem_word(e));
          check("xfer_pc4",   bus.pcplus4_d, e + 32'd4);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      n_xfer = 0; n_stall = 0; n_redir = 0;
    end else begin
      n_xfer  += int'(inc_x);
      n_stall += int'(inc_s);
      n_redir += int'(inc_r);
    end
  end

  task automatic tick(input bit rdy, input bit redir, input logic [31:0] tgt);
    @(posedge clk); #1;
    reset           = 1'b0;
    bus.ready_d     = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = redir ? tgt : $urandom;
    if (redir) begin
      exp_q.delete();
      exp_q.push_back(tgt & ~32'd3);
    end
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.ready_d     = 1'b0;
    bus.redirect_pc = '0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    @(negedge clk);
    check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus.valid_d},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_perf_fetched",   bus.perf_fetched,   32'd0);
    check("rst_perf_redirects", bus.perf_redirects, 32'd0);
    check("rst_perf_stalls",    bus.perf_stalls,    32'd0);
  endtask

  task automatic wait_valid(input bit rdy, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(rdy, 1'b0, 32'h0);
      if (bus.valid_d) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: valid_d never rose, expected within 30 cycles", name);
    end
  endtask

  initial begin
    bit ok;
    int nreq;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.ready_d     = 1'b0;

    // Streaming from reset, single-cycle memory
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      check("t1_req",   {31'd0, bus.imem_req}, 32'd1);
      check("t1_addr",  bus.imem_addr, 32'(k * 4));
      check("t1_valid", {31'd0, bus.valid_d}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) check("t1_pc", bus.pc_d, 32'((k - 2) * 4));
    end

    // Decode stalled: credit limits requests, outputs hold
    do_reset();
    nreq = 0;
    ok   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 32'h0);
      nreq += int'(bus.imem_req);
      if (bus.valid_d) begin ok = 1'b1; break; end
    end
    check("t2_valid_seen", {31'd0, ok}, 32'd1);
    for (int k = 1; k < 10; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      nreq += int'(bus.imem_req);
      check("t2_hold_pc",    bus.pc_d,    32'h0);
      check("t2_hold_instr", bus.instr_d, mem_word(32'h0));
    end
    check("t2_req_count", 32'(nreq), 32'd4);
    check("t2_req_idle",  {31'd0, bus.imem_req}, 32'd0);
    tick(1'b1, 1'b0, 32'h0);
    check("t2_perf_stalls", bus.perf_stalls, PERF ? 32'd10 : 32'd0);

    // Redirect with three live requests and no response that cycle
    lat_lo = 4; lat_hi = 4;
    do_reset();
    repeat (3) tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h0000_0103);
    check("t3_no_req_on_redirect", {31'd0, bus.imem_req}, 32'd0);
    tick(1'b1, 1'b0, 32'h0);
    check("t3_valid_after", {31'd0, bus.valid_d}, 32'd0);
    check("t3_req",  {31'd0, bus.imem_req}, 32'd1);
    check("t3_addr", bus.imem_addr, 32'h0000_0100);
    check("t3_perf_redirects", bus.perf_redirects, PERF ? 32'd1 : 32'd0);
    wait_valid(1'b1, "t3_wait", ok);
    if (ok) check("t3_first_pc", bus.pc_d, 32'h0000_0100);

    // Redirect coinciding with a response and a decode pop
    lat_lo = 2; lat_hi = 2;
    do_reset();
    repeat (3) tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h0000_0040);
    check("t4_valid_in", {31'd0, bus.valid_d}, 32'd1);
    check("t4_pc_in",    bus.pc_d, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("t4_flushed", {31'd0, bus.valid_d}, 32'd0);
    check("t4_perf_fetched", bus.perf_fetched, 32'd0);
    wait_valid(1'b1, "t4_wait", ok);
    if (ok) check("t4_first_pc", bus.pc_d, 32'h0000_0040);

    // Address wrap at the top of the space
    lat_lo = 1; lat_hi = 1;
    do_reset();
    repeat (2) tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    tick(1'b1, 1'b0, 32'h0);
    check("t5_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    tick(1'b1, 1'b0, 32'h0);
    check("t5_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    tick(1'b1, 1'b0, 32'h0);
    check("t5_addr2", bus.imem_addr, 32'h0000_0000);
    check("t5_pc0",   bus.pc_d, 32'hFFFF_FFF8);
    tick(1'b1, 1'b0, 32'h0);
    check("t5_pc1",   bus.pc_d, 32'hFFFF_FFFC);
    check("t5_pc4_wrap", bus.pcplus4_d, 32'h0);

    // Back-to-back redirects
    lat_lo = 2; lat_hi = 2;
    do_reset();
    repeat (4) tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 32'h0000_0200);
    tick(1'b1, 1'b1, 32'h0000_0300);
    wait_valid(1'b1, "t6_wait", ok);
    if (ok) check("t6_first_pc", bus.pc_d, 32'h0000_0300);

    // Random traffic: latency, stalls and redirects all varied
    lat_lo = 1; lat_hi = 4;
    do_reset();
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0, $urandom);
    tick(1'b0, 1'b0, 32'h0);
    check("rand_perf_fetched",   bus.perf_fetched,   PERF ? 32'(n_xfer)  : 32'd0);
    check("rand_perf_redirects", bus.perf_redirects, PERF ? 32'(n_redir) : 32'd0);
    check("rand_perf_stalls",    bus.perf_stalls,    PERF ? 32'(n_stall) : 32'd0);
    check("rand_progress", {31'd0, n_xfer > 200}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
